// File: rtl/pset01_toggle_arbiter_if.sv
// Request/grant bundle between requesters and the shared toggle-line arbiter.
// The master side drives the requests and burst lengths; the slave side is the arbiter.
interface pset01_toggle_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LEN_W = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LEN_W-1:0] len;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic                   done;
    logic                   out;

    modport master (
        output req,
        output len,
        input  grant,
        input  busy,
        input  done,
        input  out
    );

    modport slave (
        input  req,
        input  len,
        output grant,
        output busy,
        output done,
        output out
    );
endinterface

// File: rtl/pset01_toggle_arbiter.sv
// Round-robin arbiter for a shared toggle line: one winner at a time gets a
// burst of L alternating 1/0 cycles, followed by a one-cycle done pulse.
module pset01_toggle_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LEN_W = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    pset01_toggle_arbiter_if.slave bus
);
    localparam int unsigned IdxW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              out_q, out_d;

    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic [LEN_W-1:0]  win_len;

    // Index reached by stepping 'off' places past 'base', wrapping at N_REQ.
    function automatic logic [IdxW-1:0] rr_index(input logic [IdxW-1:0] base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % N_REQ;
        return IdxW'(sum);
    endfunction

    // Round-robin search: start just past the last winner, first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            if (!win_found && bus.req[rr_index(last_q, off)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(last_q, off);
            end
        end
        win_len = bus.len[32'(win_idx) * LEN_W +: LEN_W];
    end

    // Next-state logic: arbitrate in idle, count the burst down in run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                out_d   = 1'b0;
                if (win_found) begin
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    last_d  = win_idx;
                    cnt_d   = win_len;
                    if (win_len != '0) begin
                        state_d = StRun;
                        out_d   = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (cnt_q > LEN_W'(1)) begin
                    // Stay in run; the counter stops at 1 so it can never wrap.
                    cnt_d = cnt_q - LEN_W'(1);
                    out_d = ~out_q;
                end else begin
                    state_d = StDone;
                    out_d   = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
                grant_d = '0;
                out_d   = 1'b0;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any burst immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= IdxW'(N_REQ - 1);
            grant_q <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            out_q   <= out_d;
        end
    end

    // Outputs come straight from registered state, never from req or len.
    assign bus.grant = grant_q;
    assign bus.busy  = (state_q != StIdle);
    assign bus.done  = (state_q == StDone);
    assign bus.out   = out_q;
endmodule
